// File: rtl/bias_rw_ctrl.sv
// Bias buffer controller: fills a single-port bias SRAM from a FWFT stream
// and replays it one kernel group at a time; tst_sram_rw selects the port owner.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   bias_write_data_din        FIFO head word (valid while empty_n is high)
//   bias_write_empty_n_din     FIFO not empty
//   bias_write_read_dout       FIFO pop strobe (combinational)
//   start_bias_write           write transaction start (level or pulse)
//   bias_write_busy/_done      write status, done is a one-cycle pulse
//   start_bias_read            read transaction start (level or pulse)
//   bias_read_busy/_done       read status, done is a one-cycle pulse
//   tst_cp_ker_num             kernel group index (low bits used)
//   tst_en_ker_num             group reload request pulse
//   tst_ker_read_done          all groups consumed by the kernel reader
//   tst_sram_rw                SRAM owner: 1 = write FSM, 0 = read FSM
//   bias_dout/_valid/_last     bias word stream, last marks the final group word
module bias_rw_ctrl #(
    parameter int DATA_W      = 64,
    parameter int BIAS_WORDS  = 64,
    parameter int GROUP_WORDS = 8,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bias_write_data_din,
    input  logic              bias_write_empty_n_din,
    output logic              bias_write_read_dout,
    input  logic              start_bias_write,
    output logic              bias_write_busy,
    output logic              bias_write_done,
    input  logic              start_bias_read,
    output logic              bias_read_busy,
    output logic              bias_read_done,
    input  logic [9:0]        tst_cp_ker_num,
    input  logic              tst_en_ker_num,
    input  logic              tst_ker_read_done,
    input  logic              tst_sram_rw,
    output logic [DATA_W-1:0] bias_dout,
    output logic              bias_dout_valid,
    output logic              bias_dout_last
);

    localparam int OFF_W = $clog2(GROUP_WORDS);
    localparam int GRP_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        W_IDLE,
        W_RUN,
        W_DONE
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LOAD,
        R_WAIT,
        R_DONE
    } r_state_t;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    w_state_t          w_state_q;
    w_state_t          w_state_d;
    logic [ADDR_W-1:0] waddr_q;
    logic              w_arm_q;
    logic              w_accept;
    logic              pop;
    logic              w_busy;
    logic              w_done;

    // A start is only taken once the line has been seen low while idle,
    // so a held start cannot relaunch a second transaction.
    assign w_accept = (w_state_q == W_IDLE) && start_bias_write && w_arm_q;

    always_comb begin
        w_state_d = w_state_q;
        pop       = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (w_accept) w_state_d = W_RUN;
            end
            W_RUN: begin
                w_busy = 1'b1;
                pop    = bias_write_empty_n_din & tst_sram_rw;
                if (pop && (waddr_q == ADDR_W'(BIAS_WORDS - 1)))
                    w_state_d = W_DONE;
            end
            W_DONE: begin
                w_done    = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            w_arm_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (w_state_q == W_DONE)
                waddr_q <= '0;
            else if (pop)
                waddr_q <= waddr_q + 1'b1;
            if (w_accept)
                w_arm_q <= 1'b0;
            else if (!start_bias_write && (w_state_q == W_IDLE))
                w_arm_q <= 1'b1;
        end
    end

    assign bias_write_read_dout = pop;
    assign bias_write_busy      = w_busy;
    assign bias_write_done      = w_done;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    r_state_t         r_state_q;
    r_state_t         r_state_d;
    logic [GRP_W-1:0] group_q;
    logic [OFF_W-1:0] rcnt_q;
    logic             r_arm_q;
    logic             reload_q;
    logic             fin_q;
    logic             r_accept;
    logic             rd_issue;
    logic             rd_last;
    logic             r_busy;
    logic             r_done;
    logic             unused_cp;

    assign unused_cp = ^tst_cp_ker_num[9:GRP_W];

    assign r_accept = (r_state_q == R_IDLE) && start_bias_read && r_arm_q;
    assign rd_issue = (r_state_q == R_LOAD) && !tst_sram_rw;
    assign rd_last  = rd_issue && (rcnt_q == OFF_W'(GROUP_WORDS - 1));

    always_comb begin
        r_state_d = r_state_q;
        r_busy    = 1'b0;
        r_done    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (r_accept) r_state_d = R_LOAD;
            end
            R_LOAD: begin
                r_busy = 1'b1;
                if (rd_last) r_state_d = R_WAIT;
            end
            R_WAIT: begin
                r_busy = 1'b1;
                if (fin_q || tst_ker_read_done)
                    r_state_d = R_DONE;
                else if (reload_q)
                    r_state_d = R_LOAD;
            end
            R_DONE: begin
                r_done    = 1'b1;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // reload_q delays the group sample by one cycle after the enable pulse,
    // so an index that changes as the enable drops is still picked up.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            group_q   <= '0;
            rcnt_q    <= '0;
            r_arm_q   <= 1'b0;
            reload_q  <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (r_accept)
                r_arm_q <= 1'b0;
            else if (!start_bias_read && (r_state_q == R_IDLE))
                r_arm_q <= 1'b1;
            unique case (r_state_q)
                R_IDLE: begin
                    if (r_accept) begin
                        group_q  <= tst_cp_ker_num[GRP_W-1:0];
                        rcnt_q   <= '0;
                        reload_q <= 1'b0;
                        fin_q    <= 1'b0;
                    end
                end
                R_LOAD: begin
                    if (rd_issue) rcnt_q <= rcnt_q + 1'b1;
                    if (tst_en_ker_num) reload_q <= 1'b1;
                    if (tst_ker_read_done) fin_q <= 1'b1;
                end
                R_WAIT: begin
                    if (fin_q || tst_ker_read_done) begin
                        fin_q <= 1'b0;
                    end else if (reload_q) begin
                        group_q  <= tst_cp_ker_num[GRP_W-1:0];
                        rcnt_q   <= '0;
                        reload_q <= 1'b0;
                    end else if (tst_en_ker_num) begin
                        reload_q <= 1'b1;
                    end
                end
                R_DONE: begin
                    reload_q <= 1'b0;
                    fin_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bias_read_busy = r_busy;
    assign bias_read_done = r_done;

    // ------------------------------------------------------------------
    // Shared single-port SRAM
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [BIAS_WORDS];
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata_q;

    assign addr = tst_sram_rw ? waddr_q : {group_q, rcnt_q};

    always_ff @(posedge clk) begin
        if (pop) mem[addr] <= bias_write_data_din;
        rdata_q <= mem[addr];
    end

    // ------------------------------------------------------------------
    // Output stage: one cycle SRAM latency plus one output register
    // ------------------------------------------------------------------
    logic              p1_q;
    logic              p1_last_q;
    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q      <= 1'b0;
            p1_last_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            p1_q      <= rd_issue;
            p1_last_q <= rd_last;
            valid_q   <= p1_q;
            last_q    <= p1_last_q;
            if (p1_q) dout_q <= rdata_q;
        end
    end

    assign bias_dout       = dout_q;
    assign bias_dout_valid = valid_q;
    assign bias_dout_last  = last_q;

endmodule

// File: tb/tb_bias_rw_ctrl.sv
// Directed bench for bias_rw_ctrl: streamed writes, group reads,
// reload pacing, read completion and mid-write reset.
module tb_bias_rw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] din;
    logic        empty_n;
    logic        pop;
    logic        wr_start;
    logic        wr_busy;
    logic        wr_done;
    logic        rd_start;
    logic        rd_busy;
    logic        rd_done;
    logic [9:0]  cp;
    logic        en;
    logic        ker_done;
    logic        sram_rw;
    logic [63:0] dout;
    logic        dvalid;
    logic        dlast;

    always #5 clk = ~clk;

    bias_rw_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .bias_write_data_din    (din),
        .bias_write_empty_n_din (empty_n),
        .bias_write_read_dout   (pop),
        .start_bias_write       (wr_start),
        .bias_write_busy        (wr_busy),
        .bias_write_done        (wr_done),
        .start_bias_read        (rd_start),
        .bias_read_busy         (rd_busy),
        .bias_read_done         (rd_done),
        .tst_cp_ker_num         (cp),
        .tst_en_ker_num         (en),
        .tst_ker_read_done      (ker_done),
        .tst_sram_rw            (sram_rw),
        .bias_dout              (dout),
        .bias_dout_valid        (dvalid),
        .bias_dout_last         (dlast)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0101_0101_0101_0101 * 64'(i);
    endfunction

    // FWFT FIFO model: an endless source of pattern words
    int   fifo_idx = 0;
    logic fifo_on;
    logic fifo_clr;
    assign din     = pat(fifo_idx);
    assign empty_n = fifo_on;

    always @(posedge clk) begin
        if (fifo_clr) fifo_idx <= 0;
        else if (pop) fifo_idx <= fifo_idx + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled on the falling edge
    int          pops = 0, wdones = 0, wbusy_cyc = 0, rdones = 0;
    int          last_pop_cyc = 0, done_cyc = 0;
    logic [63:0] rq[$];
    logic        lq[$];
    int          cq[$];

    always @(negedge clk) begin
        if (pop) begin
            pops++;
            last_pop_cyc = cyc;
        end
        if (wr_done) begin
            wdones++;
            done_cyc = cyc;
        end
        if (wr_busy) wbusy_cyc++;
        if (rd_done) rdones++;
        if (dvalid) begin
            rq.push_back(dout);
            lq.push_back(dlast);
            cq.push_back(cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input bit stall);
        int  p0 = pops;
        int  d0 = wdones;
        int  b0 = wbusy_cyc;
        int  n  = 0;
        bit  stalled = 0;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        wr_start = 1'b1;
        tick(4);
        wr_start = 1'b0;
        while ((pops - p0) < 64 && n < 2000) begin
            if (stall && !stalled && (pops - p0) == 21) begin
                stalled = 1;
                fifo_on = 1'b0;
                tick(10);
                fifo_on = 1'b1;
            end else begin
                tick();
            end
            n++;
        end
        tick(3);
        chk("wr_pops", 64'(pops - p0), 64'd64);
        chk("wr_done_cnt", 64'(wdones - d0), 64'd1);
        chk("wr_done_lat", 64'(done_cyc - last_pop_cyc), 64'd1);
        chk("wr_busy_cyc", 64'(wbusy_cyc - b0), stall ? 64'd74 : 64'd64);
        chk("wr_busy_end", 64'(wr_busy), 64'd0);
    endtask

    task automatic check_group(input int r0, input int g);
        int n = 0;
        while (rq.size() < r0 + 8 && n < 200) begin
            tick();
            n++;
        end
        tick(3);
        chk($sformatf("g%0d_cnt", g), 64'(rq.size() - r0), 64'd8);
        if (rq.size() >= r0 + 8) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("g%0d_w%0d", g, j), rq[r0+j], pat(8 * g + j));
                chk($sformatf("g%0d_l%0d", g, j), 64'(lq[r0+j]),
                    64'(j == 7));
            end
            chk($sformatf("g%0d_span", g), 64'(cq[r0+7] - cq[r0]), 64'd7);
        end
    endtask

    initial begin
        int k;
        int r0;
        int d0;
        int p0;
        int n;
        reset    = 1'b1;
        wr_start = 1'b0;
        rd_start = 1'b0;
        cp       = '0;
        en       = 1'b0;
        ker_done = 1'b0;
        sram_rw  = 1'b1;
        fifo_on  = 1'b1;
        fifo_clr = 1'b1;
        tick(3);
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_wbusy", 64'(wr_busy), 64'd0);
        chk("rst_wdone", 64'(wr_done), 64'd0);
        chk("rst_rbusy", 64'(rd_busy), 64'd0);
        chk("rst_rdone", 64'(rd_done), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_valid", 64'(dvalid), 64'd0);
        chk("rst_last", 64'(dlast), 64'd0);
        reset    = 1'b0;
        fifo_clr = 1'b0;
        tick(2);

        do_write(1'b0);
        do_write(1'b1);

        sram_rw = 1'b0;
        tick();
        r0 = rq.size();
        d0 = rdones;
        cp = 10'd0;
        rd_start = 1'b1;
        k = cyc;
        tick();
        rd_start = 1'b0;
        chk("rd_busy", 64'(rd_busy), 64'd1);
        check_group(r0, 0);
        if (cq.size() > r0) chk("rd_lat", 64'(cq[r0] - k), 64'd3);

        for (int g = 1; g < 8; g++) begin
            tick(6);
            r0 = rq.size();
            en = 1'b1;
            tick();
            en = 1'b0;
            cp = 10'(g);
            tick();
            check_group(r0, g);
        end
        if (rq.size() > 0) chk("last_word", rq[rq.size()-1], pat(63));

        ker_done = 1'b1;
        tick();
        ker_done = 1'b0;
        tick(3);
        chk("rd_done_cnt", 64'(rdones - d0), 64'd1);
        chk("rd_busy_end", 64'(rd_busy), 64'd0);

        cp = 10'd0;
        r0 = rq.size();
        rd_start = 1'b1;
        tick(3);
        rd_start = 1'b0;
        check_group(r0, 0);
        ker_done = 1'b1;
        tick();
        ker_done = 1'b0;
        tick(3);

        sram_rw  = 1'b1;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        p0 = pops;
        d0 = wdones;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        n = 0;
        while ((pops - p0) < 30 && n < 500) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(wr_busy), 64'd0);
        chk("mid_rst_done", 64'(wr_done), 64'd0);
        tick(2);
        chk("mid_rst_nodone", 64'(wdones - d0), 64'd0);
        do_write(1'b0);

        sram_rw = 1'b0;
        tick();
        r0 = rq.size();
        cp = 10'd5;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check_group(r0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
